// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron MAC datapath.
// Contents: legal lane-count limits, IEEE-754 single-precision word width and
// constants (+0, quiet NaN, sign bit index), and the bit layout of the
// {overflow, underflow, exception} flag vector.
package nn_pkg;

    localparam int unsigned N_IN_MIN = 2;
    localparam int unsigned N_IN_MAX = 16;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_SIGN_BIT = 31;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN     = 32'h7fc0_0000;
    localparam logic [7:0]      FP_EXP_MAX  = 8'hff;

    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned FLAG_OVF = 2;
    localparam int unsigned FLAG_UNF = 1;
    localparam int unsigned FLAG_EXC = 0;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/FPAddition.sv
// Combinational IEEE-754 single-precision adder.
// Ports:
//   a, b       - operands
//   result     - a + b, rounded toward zero; subnormal inputs are treated as zero
//   overflow   - finite result too large, result forced to signed infinity
//   underflow  - nonzero result too small, result forced to signed zero
//   exception  - NaN operand or inf - inf, result is a quiet NaN
module FPAddition
    import nn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              swap, big_s, sml_s, found;
    logic [7:0]        big_e, sml_e, diff;
    logic [26:0]       big_m, sml_m, sml_sh;
    logic [27:0]       sum, norm;
    logic [4:0]        lz;
    logic signed [9:0] res_e;
    logic              unused_bits;

    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == FP_EXP_MAX) && (a[22:0] == 23'h0);
    assign b_inf  = (b[30:23] == FP_EXP_MAX) && (b[22:0] == 23'h0);
    assign a_nan  = (a[30:23] == FP_EXP_MAX) && (a[22:0] != 23'h0);
    assign b_nan  = (b[30:23] == FP_EXP_MAX) && (b[22:0] != 23'h0);

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        exception = 1'b0;
        swap      = (b[30:0] > a[30:0]);
        big_s     = swap ? b[31] : a[31];
        sml_s     = swap ? a[31] : b[31];
        big_e     = swap ? b[30:23] : a[30:23];
        sml_e     = swap ? a[30:23] : b[30:23];
        // Three guard bits below the 24-bit mantissa keep subtraction accurate.
        big_m     = swap ? {1'b1, b[22:0], 3'b000} : {1'b1, a[22:0], 3'b000};
        sml_m     = swap ? {1'b1, a[22:0], 3'b000} : {1'b1, b[22:0], 3'b000};
        diff      = big_e - sml_e;
        sml_sh    = (diff > 8'd26) ? '0 : (sml_m >> diff);
        sum       = (big_s == sml_s) ? ({1'b0, big_m} + {1'b0, sml_sh})
                                     : ({1'b0, big_m} - {1'b0, sml_sh});
        lz        = '0;
        found     = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(27 - i);
                found = 1'b1;
            end
        end
        norm  = sum << lz;
        // Leading one at bit 26 means exponent big_e; bit 27 means one higher.
        res_e = $signed({2'b00, big_e}) + 10'sd1 - $signed({5'b00000, lz});

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            result    = FP_QNAN;
            exception = 1'b1;
        end else if (a_inf) begin
            result = a;
        end else if (b_inf) begin
            result = b;
        end else if (a_zero && b_zero) begin
            result = {a[31] & b[31], 31'h0};
        end else if (a_zero) begin
            result = b;
        end else if (b_zero) begin
            result = a;
        end else if (!found) begin
            result = FP_POS_ZERO;
        end else if (res_e >= 10'sd255) begin
            result   = {big_s, 8'hff, 23'h0};
            overflow = 1'b1;
        end else if (res_e <= 10'sd0) begin
            result    = {big_s, 31'h0};
            underflow = 1'b1;
        end else begin
            result = {big_s, res_e[7:0], norm[26:4]};
        end
        // Hidden bit and truncated guard bits.
        unused_bits = ^{norm[27], norm[3:0]};
    end

endmodule

// File: rtl/FPMultiplication.sv
// Combinational IEEE-754 single-precision multiplier.
// Ports:
//   a, b       - operands
//   result     - a * b, rounded toward zero; subnormal inputs are treated as zero
//   overflow   - finite result too large, result forced to signed infinity
//   underflow  - nonzero result too small, result forced to signed zero
//   exception  - NaN operand or inf * 0, result is a quiet NaN
module FPMultiplication
    import nn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              res_s;
    logic [47:0]       prod;
    logic signed [9:0] res_e;
    logic [22:0]       frac;
    logic              unused_bits;

    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == FP_EXP_MAX) && (a[22:0] == 23'h0);
    assign b_inf  = (b[30:23] == FP_EXP_MAX) && (b[22:0] == 23'h0);
    assign a_nan  = (a[30:23] == FP_EXP_MAX) && (a[22:0] != 23'h0);
    assign b_nan  = (b[30:23] == FP_EXP_MAX) && (b[22:0] != 23'h0);

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        exception = 1'b0;
        prod      = '0;
        res_e     = '0;
        frac      = '0;
        res_s     = a[31] ^ b[31];
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result    = FP_QNAN;
            exception = 1'b1;
        end else if (a_inf || b_inf) begin
            result = {res_s, 8'hff, 23'h0};
        end else if (a_zero || b_zero) begin
            result = {res_s, 31'h0};
        end else begin
            prod  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
            res_e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            // Product of two 1.x mantissas lies in [1, 4); renormalise the [2, 4) case.
            if (prod[47]) begin
                frac  = prod[46:24];
                res_e = res_e + 10'sd1;
            end else begin
                frac = prod[45:23];
            end
            if (res_e >= 10'sd255) begin
                result   = {res_s, 8'hff, 23'h0};
                overflow = 1'b1;
            end else if (res_e <= 10'sd0) begin
                result    = {res_s, 31'h0};
                underflow = 1'b1;
            end else begin
                result = {res_s, res_e[7:0], frac};
            end
        end
        // Truncated low product bits.
        unused_bits = ^prod[22:0];
    end

endmodule

// File: rtl/fp_adder_tree.sv
// Combinational balanced tree of FPAddition blocks reducing N_IN terms to one sum.
// Nodes are laid out heap-style: 0..N_IN-1 are the leaves, node N_IN+k is the sum
// of nodes 2k and 2k+1, and the root is node 2*N_IN-2, giving log2(N_IN) levels.
// Ports:
//   terms  - N_IN single-precision inputs
//   sum    - single-precision total
//   flags  - {overflow, underflow, exception} ORed over every adder in the tree
module fp_adder_tree
    import nn_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned W    = 32
) (
    input  logic [N_IN-1:0][W-1:0] terms,
    output logic [W-1:0]           sum,
    output flags_t                 flags
);

    localparam int unsigned N_ADD = N_IN - 1;

    logic [W-1:0]     node [2*N_IN-1];
    logic [N_ADD-1:0] add_ovf, add_unf, add_exc;

    for (genvar i = 0; i < N_IN; i++) begin : g_leaf
        assign node[i] = terms[i];
    end

    for (genvar k = 0; k < N_ADD; k++) begin : g_add
        FPAddition u_add (
            .a         (node[2*k]),
            .b         (node[2*k+1]),
            .result    (node[N_IN+k]),
            .overflow  (add_ovf[k]),
            .underflow (add_unf[k]),
            .exception (add_exc[k])
        );
    end

    assign sum = node[2*N_IN-2];

    always_comb begin
        flags           = '0;
        flags[FLAG_OVF] = |add_ovf;
        flags[FLAG_UNF] = |add_unf;
        flags[FLAG_EXC] = |add_exc;
    end

endmodule

// File: rtl/neuron_mac_pipe.sv
// Three-stage floating-point multiply-accumulate for a neuron dot product.
// S1 registers the N_IN lane products, S2 registers their tree sum, S3 accumulates
// beats into acc and presents the result when the last beat of a vector arrives.
// The whole pipe stalls together while a result waits to be consumed.
// Parameters: N_IN lanes (2, 4, 8 or 16), W word width (32 only).
// Ports:
//   clock, reset_n      - rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   - input beat handshake; in_last marks a vector's final beat
//   x, w                - per-lane activations and weights
//   relu_en             - taken with the last beat; clamps negative results to +0
//   out_valid/out_ready - result handshake
//   out, s              - result word and its nonzero indicator
//   flags               - {overflow, underflow, exception} sticky over the vector
module neuron_mac_pipe
    import nn_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned W    = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [N_IN-1:0][W-1:0] x,
    input  logic [N_IN-1:0][W-1:0] w,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out,
    output logic                   s,
    output flags_t                 flags
);

    logic                   advance;
    logic [N_IN-1:0][W-1:0] prod;
    logic [N_IN-1:0]        mul_ovf, mul_unf, mul_exc;
    flags_t                 mul_flags;

    logic                   s1_valid_q, s1_last_q, s1_relu_q;
    flags_t                 s1_flags_q;
    logic [N_IN-1:0][W-1:0] s1_prod_q;

    logic [W-1:0]           tree_sum;
    flags_t                 tree_flags;

    logic                   s2_valid_q, s2_last_q, s2_relu_q;
    flags_t                 s2_flags_q;
    logic [W-1:0]           s2_sum_q;

    logic [W-1:0]           acc_q, acc_d, acc_sum;
    flags_t                 flags_q, flags_d, acc_flags;
    logic                   relu_q, first_q, out_valid_q;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;

    for (genvar i = 0; i < N_IN; i++) begin : g_mul
        FPMultiplication u_mul (
            .a         (x[i]),
            .b         (w[i]),
            .result    (prod[i]),
            .overflow  (mul_ovf[i]),
            .underflow (mul_unf[i]),
            .exception (mul_exc[i])
        );
    end

    always_comb begin
        mul_flags           = '0;
        mul_flags[FLAG_OVF] = |mul_ovf;
        mul_flags[FLAG_UNF] = |mul_unf;
        mul_flags[FLAG_EXC] = |mul_exc;
    end

    fp_adder_tree #(
        .N_IN (N_IN),
        .W    (W)
    ) u_tree (
        .terms (s1_prod_q),
        .sum   (tree_sum),
        .flags (tree_flags)
    );

    FPAddition u_acc_add (
        .a         (acc_q),
        .b         (s2_sum_q),
        .result    (acc_sum),
        .overflow  (acc_flags[FLAG_OVF]),
        .underflow (acc_flags[FLAG_UNF]),
        .exception (acc_flags[FLAG_EXC])
    );

    // The first beat of a vector loads acc and restarts the sticky flags, which
    // also discards whatever the previous vector left behind.
    always_comb begin
        acc_d   = first_q ? s2_sum_q : acc_sum;
        flags_d = first_q ? s2_flags_q : (flags_q | s2_flags_q | acc_flags);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_relu_q   <= 1'b0;
            s1_flags_q  <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_relu_q   <= 1'b0;
            s2_flags_q  <= '0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            relu_q      <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_prod_q  <= prod;
                s1_last_q  <= in_last;
                s1_relu_q  <= relu_en;
                s1_flags_q <= mul_flags;
            end

            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q   <= tree_sum;
                s2_last_q  <= s1_last_q;
                s2_relu_q  <= s1_relu_q;
                s2_flags_q <= s1_flags_q | tree_flags;
            end

            // A bubble in S2 leaves acc untouched and retires any consumed result.
            if (s2_valid_q) begin
                acc_q       <= acc_d;
                flags_q     <= flags_d;
                first_q     <= s2_last_q;
                out_valid_q <= s2_last_q;
                if (s2_last_q) begin
                    relu_q <= s2_relu_q;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // -0.0 has the sign bit set, so it is clamped to +0 as well.
    always_comb begin
        out = (relu_q && acc_q[FP_SIGN_BIT]) ? FP_POS_ZERO : acc_q;
        s   = (out != FP_POS_ZERO);
    end

endmodule

// File: tb/tb_neuron_mac_pipe.sv
module tb_neuron_mac_pipe;

    localparam int unsigned N = 4;

    localparam logic [31:0] ZERO   = 32'h0000_0000;
    localparam logic [31:0] NZERO  = 32'h8000_0000;
    localparam logic [31:0] ONE    = 32'h3F80_0000;
    localparam logic [31:0] TWO    = 32'h4000_0000;
    localparam logic [31:0] THREE  = 32'h4040_0000;
    localparam logic [31:0] FOUR   = 32'h4080_0000;
    localparam logic [31:0] M1     = 32'hBF80_0000;
    localparam logic [31:0] TEN    = 32'h4120_0000;
    localparam logic [31:0] M10    = 32'hC120_0000;
    localparam logic [31:0] TWENTY = 32'h41A0_0000;
    localparam logic [31:0] BIG    = 32'h7F00_0000;
    localparam logic [31:0] INF    = 32'h7F80_0000;

    logic               clock = 1'b0;
    logic               reset_n, in_valid, in_ready, in_last, relu_en;
    logic               out_valid, out_ready, s;
    logic [N-1:0][31:0] x, w;
    logic [31:0]        out;
    logic [2:0]         flags;

    logic [N-1:0][31:0] xv, ones;
    int                 checks = 0;
    int                 errors = 0;
    int                 waited;

    neuron_mac_pipe #(
        .N_IN (N),
        .W    (32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .x         (x),
        .w         (w),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .s         (s),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d errors", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [N-1:0][31:0] xs, input logic [N-1:0][31:0] ws,
                        input logic last, input logic relu);
        in_valid = 1'b1;
        x        = xs;
        w        = ws;
        in_last  = last;
        relu_en  = relu;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int budget, output int n);
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s timeout: out_valid=%b after %0d cycles, expected 1", tag, out_valid, n);
        end
    endtask

    task automatic result(input string tag, input logic [31:0] exp_out, input logic exp_s,
                          input logic [2:0] exp_flags);
        int n;
        wait_out(tag, 8, n);
        check({tag, " out"}, out, exp_out);
        check({tag, " s"}, 32'(s), 32'(exp_s));
        check({tag, " flags"}, 32'(flags), 32'(exp_flags));
        tick();
    endtask

    initial begin
        xv        = {FOUR, THREE, TWO, ONE};
        ones      = {4{ONE}};
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        w         = '0;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out", out, ZERO);
        check("rst s", 32'(s), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);

        // 1+2+3+4 with unit weights, latency from the accepting edge.
        send(xv, ones, 1'b1, 1'b0);
        check("t1 early out_valid", 32'(out_valid), 32'd0);
        wait_out("t1", 8, waited);
        check("t1 latency", 32'(waited), 32'd2);
        check("t1 out", out, TEN);
        check("t1 s", 32'(s), 32'd1);
        check("t1 flags", 32'(flags), 32'd0);
        tick();
        check("t1 consumed", 32'(out_valid), 32'd0);

        // Negative weights with and without ReLU.
        send(xv, {4{M1}}, 1'b1, 1'b1);
        result("t2 relu", ZERO, 1'b0, 3'b000);
        send(xv, {4{M1}}, 1'b1, 1'b0);
        result("t2 norelu", M10, 1'b1, 3'b000);

        // -0.0 result: clamped to +0 under ReLU, kept otherwise.
        send({4{NZERO}}, ones, 1'b1, 1'b1);
        result("nz relu", ZERO, 1'b0, 3'b000);
        send({4{NZERO}}, ones, 1'b1, 1'b0);
        result("nz norelu", NZERO, 1'b1, 3'b000);

        // Two-beat vector, back to back.
        send(xv, ones, 1'b0, 1'b0);
        send(xv, ones, 1'b1, 1'b0);
        result("t3", TWENTY, 1'b1, 3'b000);

        // Two-beat vector with a bubble carrying junk data and in_last.
        send(xv, ones, 1'b0, 1'b0);
        x       = {4{32'h7FC0_0000}};
        w       = {4{BIG}};
        in_last = 1'b1;
        tick();
        tick();
        tick();
        in_last = 1'b0;
        send(xv, ones, 1'b1, 1'b0);
        result("bubble", TWENTY, 1'b1, 3'b000);

        // Backpressure: three vectors fill the pipe, a fourth waits 5 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        relu_en   = 1'b0;
        x = xv;   w = ones;      tick();
        x = xv;   w = {4{M1}};   tick();
        x = ones; w = ones;      tick();
        x = xv;   w = {4{TWO}};
        check("stall first valid", 32'(out_valid), 32'd1);
        check("stall first out", out, TEN);
        check("stall in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall held valid", 32'(out_valid), 32'd1);
            check("stall held out", out, TEN);
            check("stall held s", 32'(s), 32'd1);
            check("stall held in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("stream b valid", 32'(out_valid), 32'd1);
        check("stream b out", out, M10);
        tick();
        check("stream c valid", 32'(out_valid), 32'd1);
        check("stream c out", out, FOUR);
        tick();
        check("stream d valid", 32'(out_valid), 32'd1);
        check("stream d out", out, TWENTY);
        tick();
        check("stream drained", 32'(out_valid), 32'd0);

        // Multiplier overflow is flagged with the result, then cleared.
        send({ZERO, ZERO, ZERO, BIG}, {ZERO, ZERO, ZERO, BIG}, 1'b1, 1'b0);
        result("t5 ovf", INF, 1'b1, 3'b100);
        send(xv, ones, 1'b1, 1'b0);
        result("t5 next", TEN, 1'b1, 3'b000);

        // Reset after the first beat of a 2-beat vector leaves no residue.
        send(xv, ones, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("t6 out_valid", 32'(out_valid), 32'd0);
        check("t6 in_ready", 32'(in_ready), 32'd1);
        send(xv, ones, 1'b1, 1'b0);
        result("t6", TEN, 1'b1, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac_pipe.md
NEURON_MAC_PIPE -- requirements
Module: neuron_mac_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of parallel x/w lanes; legal values 2, 4, 8, 16.
REQ-002 SHALL have parameter W, default 32, IEEE-754 single-precision word width; only 32 is legal.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  x/w beat present.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_last  input  1  marks the final beat of a vector.
REQ-008 SHALL have port x  input  N_IN x W  input activations.
REQ-009 SHALL have port w  input  N_IN x W  weights.
REQ-010 SHALL have port relu_en  input  1  sampled with the last beat; 1 clamps negative results to +0.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out  output  W  result word.
REQ-014 SHALL have port s  output  1  high when out is not 32'h0.
REQ-015 SHALL have port flags  output  3  {overflow, underflow, exception}, sticky over the vector.

Function
REQ-016 SHALL use a 3-stage pipeline: S1 registers N_IN products; S2 registers the adder-tree sum of the S1 products; S3 accumulates S2 into acc.
REQ-017 SHALL use advance = !out_valid || out_ready; all stages hold when advance is 0; in_ready = advance.
REQ-018 SHALL carry valid, last, relu_en and per-beat flags alongside the data through S1 and S2.
REQ-019 SHALL load acc with the S2 sum on the first beat of a vector and otherwise set acc = acc + S2 sum.
REQ-020 SHALL drive out_valid from S3 when the S2 beat carries last, with latency 3 cycles from the accepted last beat when out_ready stays high.
REQ-021 SHALL drive out = (relu_en && acc[31]) ? 32'h0 : acc; -0.0 (32'h80000000) with relu_en=1 SHALL yield 32'h0.
REQ-022 SHALL OR all multiplier and adder overflow, underflow and exception outputs of every beat into flags, presented with out_valid, and clear them at the first beat of the next vector.
REQ-023 SHALL hold out, s and flags stable while out_valid=1 and out_ready=0.
REQ-024 SHALL begin a new vector in S3 in the same cycle the previous result is consumed, with no bubble.
REQ-025 SHALL ignore in_last, x and w when in_valid=0; bubbles mid-vector SHALL NOT disturb acc.
REQ-026 SHALL treat a single beat with in_last=1 as a complete 1-beat vector.

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge, clear all valid bits, acc, flags and product/sum registers to 0; out_valid=0, out=0, s=0, flags=0.
REQ-028 SHALL discard a partially accumulated vector on reset mid-vector; the first beat after reset SHALL be treated as a vector start.
REQ-029 SHALL hold in_ready=1 in the cycle after reset deasserts.

Structure
REQ-030 SHALL place N_IN limits, W, the flag bit indices and the IEEE constants (+0, sign bit index) in shared package nn_pkg.
REQ-031 SHALL instantiate the existing FPMultiplication (N_IN copies) and FPAddition blocks unchanged.
REQ-032 SHALL use one sub-module fp_adder_tree, parameterised by N_IN, with log2(N_IN) combinational levels of FPAddition and ORed flags.

Verification
REQ-033 SHALL cover: x=[1.0,2.0,3.0,4.0] (3F800000,40000000,40400000,40800000), w=all 3F800000, last=1 -> out=41200000 (10.0), s=1, flags=0, out_valid 3 cycles later.
REQ-034 SHALL cover: same x with w=all BF800000, relu_en=1 -> out=00000000, s=0; relu_en=0 -> out=C1200000.
REQ-035 SHALL cover: two beats of REQ-033 stimulus, the second with last=1 -> single result 41A00000 (20.0).
REQ-036 SHALL cover: out_ready=0 for 5 cycles while vectors are streamed -> in_ready drops, out held stable, no vector lost or duplicated.
REQ-037 SHALL cover: x0=w0=7F000000, other lanes 0 -> flags[2] (overflow)=1 with the result, cleared on the next vector.
REQ-038 SHALL cover: reset_n=0 for 1 cycle after the first beat of a 2-beat vector, then a fresh 1-beat 10.0 vector -> out=41200000 (no residue).
